mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// Shares one sram-like memory port between the fetch requester (I) and the data-commit requester (D).
// Sits between the fetch/commit stages and the cache/AXI bridge. Only one transaction is outstanding at a time.
// Steers addr_ok/data_ok back to the owning requester, so commit's finish_cdata logic is unchanged.
// PARAMETERS
// ADDR_W      32  address width
// DATA_W      32  data width
// STARVE_MAX  4   consecutive D grants while i_req is pending before I is forced
// PORTS
// clk        in   1       clock, rising edge
// reset      in   1       asynchronous, active-low reset
// i_req      in   1       fetch read request; held with i_addr until i_addr_ok
// i_addr     in   ADDR_W  fetch address
// i_addr_ok  out  1       fetch address accepted
// i_data_ok  out  1       fetch read data valid on rdata
// d_req      in   1       data request; held with fields until d_addr_ok
// d_wr       in   1       1 = write, 0 = read
// d_size     in   2       0 = byte, 1 = half, 2 = word
// d_addr     in   ADDR_W  data address
// d_wdata    in   DATA_W  write data
// d_addr_ok  out  1       data address accepted
// d_data_ok  out  1       data read valid / write done
// rdata      out  DATA_W  read data, shared by I and D; qualified by *_data_ok
// m_req      out  1       bus request
// m_wr       out  1       bus write
// m_size     out  2       bus size
// m_addr     out  ADDR_W  bus address
// m_wdata    out  DATA_W  bus write data
// m_addr_ok  in   1       bus address accepted
// m_data_ok  in   1       bus response
// m_rdata    in   DATA_W  bus read data
// BEHAVIOUR
// - Reset (reset==0, asynchronous):
//   - state=IDLE; owner=D; starve_cnt=0.
//   - m_req, m_wr, m_size, m_addr, m_wdata all 0.
//   - i_addr_ok, i_data_ok, d_addr_ok, d_data_ok all 0.
// - FSM states: IDLE, ADDR, DATA.
// - IDLE:
//   - No request: stay in IDLE.
//   - Both requests: grant D, except grant I when starve_cnt==STARVE_MAX.
//   - One request: grant that requester.
//   - On grant: latch the requester's fields into the m_* registers (I: m_wr=0, m_size=2). Go to ADDR.
// - ADDR:
//   - m_req=1 (registered). Latency req->m_req is 1 cycle.
//   - On m_addr_ok: pulse the owner's *_addr_ok for 1 cycle (combinational from m_addr_ok & owner), then go to DATA.
//   - m_addr_ok && m_data_ok in the same cycle: pulse both acks that cycle and go to IDLE.
// - DATA:
//   - m_req=0.
//   - On m_data_ok: owner's *_data_ok = 1 for that cycle and rdata = m_rdata (combinational pass-through). Go to IDLE.
//   - No new grant happens in the cycle data_ok returns. The next grant is made in IDLE on the following cycle.
// - Response routing:
//   - m_addr_ok or m_data_ok arriving in IDLE, or m_data_ok in ADDR without m_addr_ok, is ignored.
//   - The non-owner never sees an ack.
// - starve_cnt:
//   - Increments (saturating at STARVE_MAX) on each D grant made while i_req=1.
//   - Clears on any I grant, and on a D grant made while i_req=0.
// - Requester field changes while waiting in ADDR are not seen: the fields were latched at grant.
// - Reset mid-transaction aborts to IDLE. Any late bus response is discarded by the IDLE rule.
// - rdata is 0 whenever no data_ok is active.
// TESTING
// - I only: i_req=1, i_addr=0xBFC00000; bus gives addr_ok at cycle 2 and data_ok at cycle 4 with m_rdata=0x3C080001
//   -> m_req high cycles 1-2; i_addr_ok at cycle 2; i_data_ok=1 with rdata=0x3C080001 at cycle 4; d_* acks stay 0.
// - Simultaneous: i_req=d_req=1, d_wr=1, d_size=0, d_addr=0x80000003, d_wdata=0xAB
//   -> D wins: m_wr=1, m_size=0, m_addr=0x80000003; I is granted in the IDLE cycle after d_data_ok.
// - Starvation: i_req held high while D requests back to back
//   -> exactly 4 D transactions, then I is granted; starve_cnt returns to 0.
// - Zero-latency bus: m_addr_ok=m_data_ok=1 in the first ADDR cycle
//   -> d_addr_ok and d_data_ok pulse in the same cycle; state returns to IDLE the next cycle.
// - Reset asserted in DATA, then m_data_ok arrives 2 cycles after release
//   -> all outputs 0 and no *_data_ok pulse.
// - Spurious m_data_ok while IDLE with no requests -> no ack on either side; rdata=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one sram-like memory port between fetch (I) and data-commit (D).
// One outstanding transaction; D has priority unless I has waited too long.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] rdata,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t            state_q;
    logic              owner_i_q;
    logic [CW-1:0]     starve_q;
    logic              m_req_q;
    logic              m_wr_q;
    logic [1:0]        m_size_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;

    logic starved;
    logic grant_i;
    logic grant_d;
    logic addr_hs;
    logic data_hs;

    assign starved = (starve_q == CW'(STARVE_MAX));
    assign grant_i = i_req & (~d_req | starved);
    assign grant_d = d_req & ~grant_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_i_q <= 1'b0;
            starve_q  <= '0;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_size_q  <= 2'd0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        state_q   <= ADDR;
                        owner_i_q <= 1'b1;
                        starve_q  <= '0;
                        m_req_q   <= 1'b1;
                        m_wr_q    <= 1'b0;
                        m_size_q  <= 2'd2;
                        m_addr_q  <= i_addr;
                        m_wdata_q <= '0;
                    end else if (grant_d) begin
                        state_q   <= ADDR;
                        owner_i_q <= 1'b0;
                        m_req_q   <= 1'b1;
                        m_wr_q    <= d_wr;
                        m_size_q  <= d_size;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                        // Only D wins that leave I waiting count toward starvation
                        if (!i_req)
                            starve_q <= '0;
                        else if (!starved)
                            starve_q <= starve_q + CW'(1);
                    end
                end
                ADDR: begin
                    if (m_addr_ok) begin
                        m_req_q <= 1'b0;
                        state_q <= m_data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (m_data_ok)
                        state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign addr_hs = (state_q == ADDR) & m_addr_ok;
    assign data_hs = m_data_ok & (addr_hs | (state_q == DATA));

    assign i_addr_ok = addr_hs & owner_i_q;
    assign d_addr_ok = addr_hs & ~owner_i_q;
    assign i_data_ok = data_hs & owner_i_q;
    assign d_data_ok = data_hs & ~owner_i_q;
    assign rdata     = data_hs ? m_rdata : '0;

    assign m_req   = m_req_q;
    assign m_wr    = m_wr_q;
    assign m_size  = m_size_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected bus
// grants and acks; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

    localparam int K_GRANT = 0;
    localparam int K_IAOK  = 1;
    localparam int K_DAOK  = 2;
    localparam int K_IDOK  = 3;
    localparam int K_DDOK  = 4;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] rdata;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    exp_t q[$];
    int   cmps;
    int   errs;
    logic mreq_prev;

    mem_bus_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok),
        .d_req(d_req),
        .d_wr(d_wr),
        .d_size(d_size),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok),
        .d_data_ok(d_data_ok),
        .rdata(rdata),
        .m_req(m_req),
        .m_wr(m_wr),
        .m_size(m_size),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok),
        .m_rdata(m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        cmps++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] addr,
                        input logic wr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic [31:0] data);
        exp_t e;
        e.kind  = kind;
        e.addr  = addr;
        e.wr    = wr;
        e.size  = size;
        e.wdata = wdata;
        e.data  = data;
        q.push_back(e);
    endtask

    task automatic push_txn(input logic is_i, input logic [31:0] addr,
                            input logic wr, input logic [1:0] size,
                            input logic [31:0] wdata, input logic [31:0] rd);
        push(K_GRANT, addr, wr, size, wdata, 32'h0);
        push(is_i ? K_IAOK : K_DAOK, 32'h0, 1'b0, 2'd0, 32'h0, 32'h0);
        push(is_i ? K_IDOK : K_DDOK, 32'h0, 1'b0, 2'd0, 32'h0, rd);
    endtask

    task automatic sb_pop(input int kind);
        exp_t e;
        logic ok;
        cmps++;
        if (q.size() == 0) begin
            errs++;
            $display("FAIL sb_unexpected: got event %0d, expected none", kind);
            return;
        end
        e  = q.pop_front();
        ok = (e.kind == kind);
        if (ok && kind == K_GRANT)
            ok = (m_addr === e.addr) && (m_wr === e.wr) &&
                 (m_size === e.size) && (!e.wr || m_wdata === e.wdata);
        if (ok && (kind == K_IDOK || kind == K_DDOK))
            ok = (rdata === e.data);
        if (!ok) begin
            errs++;
            $display("FAIL sb_event: got kind=%0d addr=%h wr=%b size=%0d wdata=%h rdata=%h, expected kind=%0d addr=%h wr=%b size=%0d wdata=%h rdata=%h",
                     kind, m_addr, m_wr, m_size, m_wdata, rdata,
                     e.kind, e.addr, e.wr, e.size, e.wdata, e.data);
        end
    endtask

    initial begin
        mreq_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (m_req && !mreq_prev) sb_pop(K_GRANT);
            if (i_addr_ok) sb_pop(K_IAOK);
            if (d_addr_ok) sb_pop(K_DAOK);
            if (i_data_ok) sb_pop(K_IDOK);
            if (d_data_ok) sb_pop(K_DDOK);
            mreq_prev = m_req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input int alat, input int dlat, input logic drop_i,
                       input logic drop_d, input logic [31:0] rd);
        int n;
        n = 0;
        while (!m_req && n < 20) begin
            step();
            n++;
        end
        check("wait_mreq", {127'h0, m_req}, 128'h1);
        if (!m_req) return;
        repeat (alat) step();
        m_addr_ok = 1'b1;
        if (dlat == 0) begin
            m_data_ok = 1'b1;
            m_rdata   = rd;
        end
        step();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
        if (drop_i) i_req = 1'b0;
        if (drop_d) d_req = 1'b0;
        if (dlat > 0) begin
            repeat (dlat - 1) step();
            m_data_ok = 1'b1;
            m_rdata   = rd;
            step();
            m_data_ok = 1'b0;
            m_rdata   = 32'h0;
        end
    endtask

    function automatic logic [127:0] outs();
        return {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_req, m_wr,
                m_size, m_addr, m_wdata, rdata};
    endfunction

    initial begin
        cmps      = 0;
        errs      = 0;
        reset     = 1'b0;
        i_req     = 1'b0;
        i_addr    = 32'h0;
        d_req     = 1'b0;
        d_wr      = 1'b0;
        d_size    = 2'd0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
        #3;
        check("reset_outputs", outs(), 128'h0);
        repeat (2) step();
        reset = 1'b1;
        step();

        // I only
        i_req  = 1'b1;
        i_addr = 32'hBFC0_0000;
        push_txn(1'b1, 32'hBFC0_0000, 1'b0, 2'd2, 32'h0, 32'h3C08_0001);
        step();
        check("ionly_mreq_c1", {127'h0, m_req}, 128'h1);
        i_addr = 32'h1234_5678;
        step();
        check("ionly_mreq_c2", {127'h0, m_req}, 128'h1);
        check("ionly_addr_latched", {96'h0, m_addr}, {96'h0, 32'hBFC0_0000});
        m_addr_ok = 1'b1;
        step();
        m_addr_ok = 1'b0;
        i_req     = 1'b0;
        check("ionly_mreq_c3", {127'h0, m_req}, 128'h0);
        step();
        m_data_ok = 1'b1;
        m_rdata   = 32'h3C08_0001;
        step();
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
        step();

        // Simultaneous: D wins, I follows after d_data_ok
        i_req   = 1'b1;
        i_addr  = 32'hBFC0_0010;
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_size  = 2'd0;
        d_addr  = 32'h8000_0003;
        d_wdata = 32'h0000_00AB;
        push_txn(1'b0, 32'h8000_0003, 1'b1, 2'd0, 32'h0000_00AB, 32'h0);
        bus(1, 2, 1'b0, 1'b1, 32'h0);
        check("simul_idle_gap", {127'h0, m_req}, 128'h0);
        push_txn(1'b1, 32'hBFC0_0010, 1'b0, 2'd2, 32'h0, 32'h1111_1111);
        step();
        check("simul_i_grant", {127'h0, m_req}, 128'h1);
        bus(0, 1, 1'b1, 1'b0, 32'h1111_1111);
        step();

        // Starvation, two rounds: the second proves the counter cleared
        for (int r = 0; r < 2; r++) begin
            i_req  = 1'b1;
            i_addr = 32'h0000_1000 + r;
            d_req  = 1'b1;
            d_wr   = 1'b0;
            d_size = 2'd2;
            for (int k = 0; k < 4; k++) begin
                d_addr = 32'h0000_2000 + 4 * k;
                push_txn(1'b0, 32'h0000_2000 + 4 * k, 1'b0, 2'd2,
                         32'h0, 32'h5000 + k);
                bus(0, 1, 1'b0, 1'b0, 32'h5000 + k);
            end
            push_txn(1'b1, 32'h0000_1000 + r, 1'b0, 2'd2, 32'h0, 32'h6000 + r);
            bus(0, 1, 1'b1, 1'b1, 32'h6000 + r);
            step();
        end

        // Zero-latency bus
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_size = 2'd1;
        d_addr = 32'h0000_3002;
        push_txn(1'b0, 32'h0000_3002, 1'b0, 2'd1, 32'h0, 32'hCAFE_F00D);
        bus(0, 0, 1'b0, 1'b1, 32'hCAFE_F00D);
        check("zl_mreq_low", {127'h0, m_req}, 128'h0);
        m_data_ok = 1'b1;
        m_rdata   = 32'h0000_0099;
        #1;
        check("zl_idle_no_ack", {96'h0, d_data_ok, i_data_ok, rdata}, 128'h0);
        step();
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
        step();

        // Reset in DATA, late response discarded
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_size = 2'd2;
        d_addr = 32'h0000_4000;
        push(K_GRANT, 32'h0000_4000, 1'b0, 2'd2, 32'h0, 32'h0);
        push(K_DAOK, 32'h0, 1'b0, 2'd0, 32'h0, 32'h0);
        step();
        check("rst_mreq", {127'h0, m_req}, 128'h1);
        m_addr_ok = 1'b1;
        step();
        m_addr_ok = 1'b0;
        d_req     = 1'b0;
        reset     = 1'b0;
        #1;
        check("rst_mid_outputs", outs(), 128'h0);
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        m_data_ok = 1'b1;
        m_rdata   = 32'h0000_0077;
        #1;
        check("rst_late_dok", outs(), 128'h0);
        step();
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
        step();

        // Spurious responses while idle
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = 32'hDEAD_BEEF;
        #1;
        check("spur_idle", outs(), 128'h0);
        step();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
        repeat (3) step();

        check("sb_drain", 128'(q.size()), 128'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
